// File: rtl/bcd_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : bcd_pkg
//  Description : Shared constants, FSM encodings, result type and saturation
//                helper for the BCD conversion arbiter (arbitre_bcd).
//  Contents    : BCD_MAX / BCD_SAT saturation limits, 2-bit state codes,
//                resultat_t {bcd, ovf}, function sature().
//  Revision    : 1.0 - initial release
// ============================================================================
package bcd_pkg;

    // Largest operand representable on two BCD digits, and the value the
    // result is clamped to when the operand exceeds it.
    localparam logic [7:0] BCD_MAX = 8'd99;
    localparam logic [7:0] BCD_SAT = 8'h99;

    // Arbiter FSM encodings
    localparam logic [1:0] IDLE    = 2'd0;
    localparam logic [1:0] CHARGE  = 2'd1;
    localparam logic [1:0] CAPTURE = 2'd2;
    localparam logic [1:0] ACQUIT  = 2'd3;

    // Registered conversion result: two BCD digits plus overflow flag
    typedef struct packed {
        logic [7:0] bcd;
        logic       ovf;
    } resultat_t;

    // Clamp the converter output: operands above BCD_MAX cannot be shown on
    // two digits, so they read as 99 with the overflow flag raised.
    function automatic resultat_t sature(input logic [7:0] op,
                                         input logic [7:0] conv);
        resultat_t r;
        if (op > BCD_MAX) begin
            r.bcd = BCD_SAT;
            r.ovf = 1'b1;
        end else begin
            r.bcd = conv;
            r.ovf = 1'b0;
        end
        return r;
    endfunction

endpackage : bcd_pkg
`default_nettype wire

// File: rtl/ConvertisseurBCD.sv
`default_nettype none
// ============================================================================
//  Module      : ConvertisseurBCD
//  Description : Combinational 8-bit binary to two-digit BCD converter.
//                Output is {tens, units}. Only meaningful for inputs 0..99;
//                larger inputs are clamped by the caller, so the tens digit
//                is simply truncated to four bits here.
//  Ports       : binaire_i [7:0] - binary operand
//                bcd_o     [7:0] - {tens[3:0], units[3:0]}
//  Revision    : 1.0 - initial release
// ============================================================================
module ConvertisseurBCD (
    input  logic [7:0] binaire_i,
    output logic [7:0] bcd_o
);

    // Division/modulo by a constant: synthesis reduces these to small
    // constant-coefficient logic for an 8-bit input.
    assign bcd_o = {4'(binaire_i / 8'd10), 4'(binaire_i % 8'd10)};

endmodule : ConvertisseurBCD
`default_nettype wire

// File: rtl/rr_selecteur.sv
`default_nettype none
// ============================================================================
//  Module      : rr_selecteur
//  Description : Combinational request selector for arbitre_bcd.
//                Default build: round-robin, first active request found when
//                scanning upward from ptr_i and wrapping modulo NB_REQ.
//                With ARBITRE_BCD_PRIO_FIXE_EN defined: fixed priority, the
//                lowest active index wins and the ptr_i port is removed.
//  Ports       : req_i    [NB_REQ-1:0] - request vector
//                ptr_i    [IDX_W-1:0]  - round-robin start index (RR only)
//                found_o               - at least one request active
//                winner_o [IDX_W-1:0]  - selected requester index
//  Revision    : 1.0 - initial release
// ============================================================================
module rr_selecteur #(
    parameter int NB_REQ = 4,
    parameter int IDX_W  = 2
) (
    input  logic [NB_REQ-1:0] req_i,
`ifndef ARBITRE_BCD_PRIO_FIXE_EN
    input  logic [IDX_W-1:0]  ptr_i,
`endif
    output logic              found_o,
    output logic [IDX_W-1:0]  winner_o
);

`ifdef ARBITRE_BCD_PRIO_FIXE_EN

    // Scan from the top down so the lowest active index is the last write.
    always_comb begin
        found_o  = |req_i;
        winner_o = '0;
        for (int k = NB_REQ - 1; k >= 0; k--) begin
            if (req_i[k]) begin
                winner_o = IDX_W'(k);
            end
        end
    end

`else

    // Index 'off' positions after 'base', wrapped modulo NB_REQ. Written
    // without '%' so NB_REQ need not be a power of two.
    function automatic logic [IDX_W-1:0] rot(input logic [IDX_W-1:0] base,
                                             input int               off);
        int s;
        s = int'(base) + off;
        if (s >= NB_REQ) begin
            s = s - NB_REQ;
        end
        return s[IDX_W-1:0];
    endfunction

    // Scan offsets from farthest to nearest so the request closest to the
    // pointer (offset 0 first) is the final assignment.
    always_comb begin
        found_o  = |req_i;
        winner_o = '0;
        for (int off = NB_REQ - 1; off >= 0; off--) begin
            if (req_i[rot(ptr_i, off)]) begin
                winner_o = rot(ptr_i, off);
            end
        end
    end

`endif

endmodule : rr_selecteur
`default_nettype wire

// File: rtl/arbitre_bcd.sv
`default_nettype none
// ============================================================================
//  Module      : arbitre_bcd
//  Description : Shares one ConvertisseurBCD among NB_REQ requesters using a
//                req/ack handshake. Each transaction walks
//                IDLE -> CHARGE -> CAPTURE -> ACQUIT, so a request seen in
//                IDLE is acknowledged three cycles later. Operands above 99
//                saturate to BCD 99 with ovf raised.
//  Build option: ARBITRE_BCD_PRIO_FIXE_EN - fixed priority (lowest index
//                wins, no rotation pointer). Undefined: round-robin.
//  Ports       : clk                    - clock, rising edge
//                rst                    - synchronous active-high reset
//                req      [NB_REQ-1:0]  - per-requester request
//                binaire  [8*NB_REQ-1:0]- operands, requester k at [8k+7:8k]
//                ack      [NB_REQ-1:0]  - one-cycle completion pulse
//                bcd_out  [7:0]         - {tens, units}, held until next ack
//                ovf                    - overflow, qualified by ack
//                grant_idx[IDX_W-1:0]   - current / last granted requester
//                busy                   - FSM outside IDLE
//  Revision    : 1.0 - initial release
// ============================================================================
module arbitre_bcd
    import bcd_pkg::*;
#(
    parameter int NB_REQ = 4,
    parameter int IDX_W  = 2
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic [NB_REQ-1:0]     req,
    input  logic [8*NB_REQ-1:0]   binaire,
    output logic [NB_REQ-1:0]     ack,
    output logic [7:0]            bcd_out,
    output logic                  ovf,
    output logic [IDX_W-1:0]      grant_idx,
    output logic                  busy
);

    // ------------------------------------------------------------------
    // State
    // ------------------------------------------------------------------
    logic [1:0]       state_q, state_d;
    logic [IDX_W-1:0] grant_q, grant_d;
    logic [7:0]       op_q,    op_d;
    resultat_t        res_q,   res_d;
`ifndef ARBITRE_BCD_PRIO_FIXE_EN
    logic [IDX_W-1:0] ptr_q,   ptr_d;
`endif

    logic             found_w;
    logic [IDX_W-1:0] winner_w;
    logic [7:0]       op_sel_w;
    logic [7:0]       conv_w;

    // ------------------------------------------------------------------
    // Requester selection
    // ------------------------------------------------------------------
    rr_selecteur #(
        .NB_REQ (NB_REQ),
        .IDX_W  (IDX_W)
    ) u_sel (
        .req_i    (req),
`ifndef ARBITRE_BCD_PRIO_FIXE_EN
        .ptr_i    (ptr_q),
`endif
        .found_o  (found_w),
        .winner_o (winner_w)
    );

    // Operand of the granted requester
    always_comb begin
        op_sel_w = 8'h00;
        for (int k = 0; k < NB_REQ; k++) begin
            if (grant_q == IDX_W'(k)) begin
                op_sel_w = binaire[8*k +: 8];
            end
        end
    end

    // ------------------------------------------------------------------
    // Shared converter, fed from the operand register so the conversion
    // path is register-to-register.
    // ------------------------------------------------------------------
    ConvertisseurBCD u_conv (
        .binaire_i (op_q),
        .bcd_o     (conv_w)
    );

    // ------------------------------------------------------------------
    // Next-state logic
    // ------------------------------------------------------------------
    always_comb begin
        state_d = state_q;
        grant_d = grant_q;
        op_d    = op_q;
        res_d   = res_q;
`ifndef ARBITRE_BCD_PRIO_FIXE_EN
        ptr_d   = ptr_q;
`endif
        case (state_q)
            IDLE: begin
                if (found_w) begin
                    grant_d = winner_w;
                    state_d = CHARGE;
                end
            end
            CHARGE: begin
                // The operand is sampled here; a requester dropping req
                // from now on does not affect the transaction.
                op_d    = op_sel_w;
                state_d = CAPTURE;
            end
            CAPTURE: begin
                res_d   = sature(op_q, conv_w);
                state_d = ACQUIT;
            end
            ACQUIT: begin
`ifndef ARBITRE_BCD_PRIO_FIXE_EN
                // Rotate: the requester after the one just served gets
                // first look at the next arbitration.
                if (grant_q == IDX_W'(NB_REQ - 1)) begin
                    ptr_d = '0;
                end else begin
                    ptr_d = grant_q + IDX_W'(1);
                end
`endif
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // ------------------------------------------------------------------
    // Registers
    // ------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
            grant_q <= '0;
            op_q    <= 8'h00;
            res_q   <= '0;
`ifndef ARBITRE_BCD_PRIO_FIXE_EN
            ptr_q   <= '0;
`endif
        end else begin
            state_q <= state_d;
            grant_q <= grant_d;
            op_q    <= op_d;
            res_q   <= res_d;
`ifndef ARBITRE_BCD_PRIO_FIXE_EN
            ptr_q   <= ptr_d;
`endif
        end
    end

    // ------------------------------------------------------------------
    // Outputs
    // ------------------------------------------------------------------
    // res_q is only loaded on the CAPTURE->ACQUIT edge, so bcd_out/ovf
    // switch exactly as ACQUIT begins and hold until the next transaction.
    always_comb begin
        ack = '0;
        if (state_q == ACQUIT) begin
            ack[grant_q] = 1'b1;
        end
    end

    assign bcd_out   = res_q.bcd;
    assign ovf       = res_q.ovf;
    assign grant_idx = grant_q;
    assign busy      = (state_q != IDLE);

endmodule : arbitre_bcd
`default_nettype wire
